// File: rtl/tone_meter.sv
// rtl/tone_meter.sv - period and peak meter for a 12-bit offset-binary tone
// Finds rising mid-level crossings with hysteresis and measures NCYC periods.
module tone_meter #(
   parameter int W     = 12,
   parameter int MID   = 2048,
   parameter int HYST  = 64,
   parameter int CNT_W = 16,
   parameter int NCYC  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W-1:0]     sample_in,
   input  logic             sample_valid,
   output logic             busy,
   output logic             result_valid,
   output logic [CNT_W-1:0] period,
   output logic [W-1:0]     peak_max,
   output logic [W-1:0]     peak_min,
   output logic             timeout
);

   localparam logic [W-1:0]     LO_THR  = W'(MID - HYST);
   localparam logic [W-1:0]     HI_THR  = W'(MID + HYST);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [7:0]       NCYC_L  = 8'(NCYC);

   typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_MEASURE, S_DONE} state_t;

   state_t           state_q;
   logic             armed_q;
   logic [CNT_W-1:0] cnt_q;
   logic [7:0]       cyc_q;
   logic [W-1:0]     max_q, min_q;
   logic             busy_q, result_valid_q, timeout_q;
   logic [CNT_W-1:0] period_q;
   logic [W-1:0]     peak_max_q, peak_min_q;

   logic             below, rise;
   logic [CNT_W-1:0] cnt_d;
   logic [7:0]       cyc_d;
   logic [W-1:0]     max_d, min_d;

   // below/above are mutually exclusive because the thresholds straddle MID
   assign below = sample_valid && (sample_in < LO_THR);
   assign rise  = sample_valid && (sample_in >= HI_THR) && armed_q;
   assign cnt_d = cnt_q + 1'b1;
   assign cyc_d = cyc_q + 8'd1;
   assign max_d = (sample_in > max_q) ? sample_in : max_q;
   assign min_d = (sample_in < min_q) ? sample_in : min_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         armed_q        <= 1'b0;
         cnt_q          <= '0;
         cyc_q          <= '0;
         max_q          <= '0;
         min_q          <= '0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         timeout_q      <= 1'b0;
         period_q       <= '0;
         peak_max_q     <= '0;
         peak_min_q     <= '0;
      end else begin
         result_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_ARM;
                  busy_q  <= 1'b1;
               end
            end
            S_ARM: begin
               if (below) begin
                  state_q <= S_SYNC;
                  armed_q <= 1'b1;
                  cnt_q   <= '0;
               end
            end
            S_SYNC: begin
               if (sample_valid) begin
                  if (rise) begin
                     state_q <= S_MEASURE;
                     armed_q <= 1'b0;
                     cnt_q   <= '0;
                     cyc_q   <= '0;
                     max_q   <= sample_in;
                     min_q   <= sample_in;
                  end else if (cnt_d == CNT_MAX) begin
                     state_q        <= S_DONE;
                     busy_q         <= 1'b0;
                     result_valid_q <= 1'b1;
                     timeout_q      <= 1'b1;
                     period_q       <= CNT_MAX;
                     peak_max_q     <= '0;
                     peak_min_q     <= '0;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end
            end
            S_MEASURE: begin
               if (sample_valid) begin
                  cnt_q <= cnt_d;
                  max_q <= max_d;
                  min_q <= min_d;
                  if (below) begin
                     armed_q <= 1'b1;
                  end else if (rise) begin
                     armed_q <= 1'b0;
                     cyc_q   <= cyc_d;
                  end
                  // a completing crossing wins over a simultaneous counter saturation
                  if ((rise && (cyc_d == NCYC_L)) || (cnt_d == CNT_MAX)) begin
                     state_q        <= S_DONE;
                     busy_q         <= 1'b0;
                     result_valid_q <= 1'b1;
                     timeout_q      <= !(rise && (cyc_d == NCYC_L));
                     period_q       <= cnt_d;
                     peak_max_q     <= max_d;
                     peak_min_q     <= min_d;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign period       = period_q;
   assign peak_max     = peak_max_q;
   assign peak_min     = peak_min_q;
   assign timeout      = timeout_q;

endmodule
